// File: rtl/usb_spiflash_sequencer.sv
// Splits one DFU command into page-sized usb_spiflash_bridge requests, gates the
// upstream byte streams to the command length and waits out flash busy periods.
module usb_spiflash_sequencer #(
   parameter int PAGE_SIZE    = 256,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic        cmd_security,
   input  logic [15:0] cmd_page,
   input  logic [15:0] cmd_length,
   output logic        done,
   output logic        error,
   input  logic        up_rd_free,
   output logic        up_rd_put,
   output logic [7:0]  up_rd_data,
   input  logic        up_wr_avail,
   output logic        up_wr_get,
   input  logic [7:0]  up_wr_data,
   output logic [15:0] br_address,
   output logic        br_security,
   output logic        br_rd_request,
   output logic        br_rd_data_free,
   output logic        br_wr_request,
   output logic        br_wr_data_avail,
   output logic [7:0]  br_wr_data,
   input  logic        br_rd_data_put,
   input  logic [7:0]  br_rd_data,
   input  logic        br_wr_busy,
   input  logic        br_wr_data_get
);

   localparam int PW = $clog2(PAGE_SIZE) + 1;
   localparam int TW = $clog2(BUSY_TIMEOUT + 4) + 1;

   typedef enum logic [2:0] {
      IDLE, RD_STREAM, RD_DRAIN, WR_PAGE, WR_WAIT_BUSY, WR_WAIT_DONE, DONE
   } state_t;

   state_t          state_reg, state_next;
   logic [16:0]     remaining_reg;
   logic [PW-1:0]   page_cnt_reg, page_len_reg;
   logic [TW-1:0]   timer_reg;
   logic [15:0]     address_reg;
   logic            security_reg;
   logic            error_reg;

   logic            accept, in_page, take_rd, take_wr;
   logic            next_page, busy_timeout;

   function automatic logic [PW-1:0] clip_page(input logic [16:0] n);
      if (n >= 17'(PAGE_SIZE))
         return PW'(PAGE_SIZE);
      else
         return n[PW-1:0];
   endfunction

   // Gates use only registered counts, so a byte past the command length is never passed on.
   assign accept  = cmd_valid && (state_reg == IDLE);
   assign in_page = page_cnt_reg < page_len_reg;
   assign take_rd = (state_reg == RD_STREAM) && br_rd_data_put && (remaining_reg != 17'd0);
   assign take_wr = (state_reg == WR_PAGE) && in_page && up_wr_avail && br_wr_data_get;

   assign cmd_ready        = (state_reg == IDLE);
   assign done             = (state_reg == DONE);
   assign error            = (state_reg == DONE) && error_reg;
   assign br_address       = address_reg;
   assign br_security      = security_reg;
   assign br_rd_request    = (state_reg == RD_STREAM);
   assign br_rd_data_free  = (state_reg == RD_STREAM) && up_rd_free;
   assign up_rd_put        = take_rd;
   assign up_rd_data       = take_rd ? br_rd_data : 8'h00;
   assign br_wr_request    = (state_reg == WR_PAGE) && in_page;
   assign br_wr_data_avail = (state_reg == WR_PAGE) && in_page && up_wr_avail;
   assign br_wr_data       = (state_reg == WR_PAGE) ? up_wr_data : 8'h00;
   assign up_wr_get        = take_wr;

   always_comb begin
      state_next   = state_reg;
      next_page    = 1'b0;
      busy_timeout = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (cmd_length == 16'd0)
                  state_next = DONE;
               else if (cmd_write)
                  state_next = WR_PAGE;
               else
                  state_next = RD_STREAM;
            end
         end
         RD_STREAM: begin
            if (take_rd && remaining_reg == 17'd1)
               state_next = RD_DRAIN;
         end
         RD_DRAIN: begin
            // Late bridge puts land here and are dropped; four cycles covers its pipeline.
            if (timer_reg == TW'(3))
               state_next = DONE;
         end
         WR_PAGE: begin
            if (take_wr && (page_cnt_reg + PW'(1)) == page_len_reg)
               state_next = WR_WAIT_BUSY;
         end
         WR_WAIT_BUSY: begin
            if (br_wr_busy) begin
               state_next = WR_WAIT_DONE;
            end else if (timer_reg == TW'(BUSY_TIMEOUT - 1)) begin
               busy_timeout = 1'b1;
               state_next   = DONE;
            end
         end
         WR_WAIT_DONE: begin
            if (!br_wr_busy) begin
               if (remaining_reg != 17'd0) begin
                  next_page  = 1'b1;
                  state_next = WR_PAGE;
               end else begin
                  state_next = DONE;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         remaining_reg <= '0;
         page_cnt_reg  <= '0;
         page_len_reg  <= '0;
         timer_reg     <= '0;
         address_reg   <= '0;
         security_reg  <= 1'b0;
         error_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;

         if (state_next != state_reg)
            timer_reg <= '0;
         else if (state_reg == RD_DRAIN || state_reg == WR_WAIT_BUSY)
            timer_reg <= timer_reg + TW'(1);

         if (accept) begin
            remaining_reg <= {1'b0, cmd_length};
            address_reg   <= cmd_page;
            security_reg  <= cmd_security;
            page_len_reg  <= clip_page({1'b0, cmd_length});
            page_cnt_reg  <= '0;
            error_reg     <= 1'b0;
         end else if (take_rd || take_wr) begin
            remaining_reg <= remaining_reg - 17'd1;
         end

         if (take_wr)
            page_cnt_reg <= page_cnt_reg + PW'(1);

         // Page address wraps 0xFFFF -> 0x0000 by plain 16-bit overflow.
         if (next_page) begin
            address_reg  <= address_reg + 16'd1;
            page_len_reg <= clip_page(remaining_reg);
            page_cnt_reg <= '0;
         end

         if (busy_timeout)
            error_reg <= 1'b1;
      end
   end

endmodule
